// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access encodings,
// the store-buffer entry layout, byte-lane masks and the load extension.
package dmem_pkg;

    localparam int WORD_W  = 32;
    // Entries keep a full 30-bit word address so the struct does not depend
    // on the RAM size; unused upper bits are constant zero.
    localparam int WADDR_W = 30;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } access_e;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [3:0]         bmask;
        logic [WORD_W-1:0]  data;
    } sb_entry_t;

    // Legal size/alignment combination; stores have no unsigned variants.
    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off,
                                          input logic is_store);
        logic ok;
        ok = 1'b0;
        case (access_e'(f3))
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !off[0];
            F3_HU:   ok = !is_store && !off[0];
            F3_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (access_e'(f3))
            F3_B, F3_BU: m = 4'b0001 << off;
            F3_H, F3_HU: m = 4'b0011 << off;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    // Move LSB-aligned store data into its byte lanes.
    function automatic logic [WORD_W-1:0] lane_shift(input logic [WORD_W-1:0] data,
                                                     input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    // Pick the addressed bytes out of a word and sign/zero extend them.
    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input logic [2:0] f3,
                                                      input logic [1:0] off);
        logic [WORD_W-1:0] sh;
        logic [WORD_W-1:0] res;
        sh  = word >> {off, 3'b000};
        res = '0;
        case (access_e'(f3))
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   res = {24'h0, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   res = {16'h0, sh[15:0]};
            F3_W:    res = sh;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram_sp.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read (read-before-write on the same address). Contents are never reset.
module dmem_ram_sp #(
    parameter int WORDS_W = 7
) (
    input  logic               clk_i,
    input  logic [WORDS_W-1:0] addr_i,
    input  logic [3:0]         we_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o
);

    logic [31:0] mem_q [2**WORDS_W];
    logic [31:0] rdata_q;

    // Masked byte writes and one-cycle read of the addressed word.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stores go into a small FIFO store buffer that drains
// into the RAM when the port is free; loads read the RAM and overlay any
// pending buffered bytes for the same word, then extend per RISC-V rules.
//
// Handshake: a store is taken on any clock edge where wr=1 and stall=0; while
// stall=1 the core keeps wr/addr/wr_data/funct3 stable. Loads are never
// stalled: rd in cycle N yields a one-cycle rd_valid pulse in cycle N+1.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic                          rd,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [2:0]                    funct3,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          stall,
    output logic                          err_misaligned,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    output logic                          sb_empty
);

    localparam int PTR_W   = $clog2(SB_DEPTH);
    localparam int CNT_W   = $clog2(SB_DEPTH+1);
    localparam int WORDS_W = ADDR_W - 2;

    // Request decode
    logic [1:0]         off;
    logic [WORDS_W-1:0] req_word;
    logic [WADDR_W-1:0] req_waddr;
    logic               ld_legal, st_legal;
    logic               load_go, push, pop, full, empty, err_d;

    assign off       = addr[1:0];
    assign req_word  = addr[ADDR_W-1:2];
    assign req_waddr = WADDR_W'(req_word);
    assign ld_legal  = access_legal(funct3, off, 1'b0);
    assign st_legal  = access_legal(funct3, off, 1'b1);

    // Store buffer state
    sb_entry_t          sb_q [SB_DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   sb_count_q;

    assign full  = (sb_count_q == CNT_W'(SB_DEPTH));
    assign empty = (sb_count_q == '0);

    // A simultaneous wr+rd drops the store; an illegal store while full must
    // not drain either, so nothing changes on any flagged request.
    assign load_go = rd && ld_legal;
    assign err_d   = (rd && !ld_legal) || (wr && rd) || (wr && !rd && !st_legal);
    assign push    = wr && !rd && st_legal && !full;
    assign pop     = !rd && !empty && (!wr || (full && st_legal));
    assign stall   = wr && full;

    // RAM port: loads own it; otherwise it carries the head drain.
    logic [WORDS_W-1:0] ram_addr;
    logic [3:0]         ram_we;
    logic [31:0]        ram_rdata;

    assign ram_addr = rd  ? req_word : sb_q[head_q].waddr[WORDS_W-1:0];
    assign ram_we   = pop ? sb_q[head_q].bmask : 4'b0000;

    dmem_ram_sp #(.WORDS_W(WORDS_W)) u_ram (
        .clk_i   (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (sb_q[head_q].data),
        .rdata_o (ram_rdata)
    );

    // Entry payload written at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_q[tail_q] <= '{waddr: req_waddr,
                              bmask: byte_mask(funct3, off),
                              data:  lane_shift(32'(wr_data), off)};
        end
    end

    // Pointer and occupancy bookkeeping; push and pop are mutually exclusive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            sb_count_q <= '0;
        end else begin
            if (push) begin
                tail_q     <= tail_q + PTR_W'(1);
                sb_count_q <= sb_count_q + CNT_W'(1);
            end else if (pop) begin
                head_q     <= head_q + PTR_W'(1);
                sb_count_q <= sb_count_q - CNT_W'(1);
            end
        end
    end

    // Forwarding: walk live entries oldest to newest so later stores win.
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;

    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_data = '0;
        fwd_mask = '0;
        idx      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < sb_count_q) && (sb_q[idx].waddr == req_waddr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (sb_q[idx].bmask[b]) begin
                        fwd_data[8*b +: 8] = sb_q[idx].data[8*b +: 8];
                        fwd_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end

    // Load pipeline: snapshot forwarding and access info alongside the RAM read.
    logic [31:0]       fwd_data_q;
    logic [3:0]        fwd_mask_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              ld_valid_q, err_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [31:0]       merged, load_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            ld_valid_q <= load_go;
            err_q      <= err_d;
            if (load_go) begin
                fwd_data_q <= fwd_data;
                fwd_mask_q <= fwd_mask;
                f3_q       <= funct3;
                off_q      <= off;
            end
            if (ld_valid_q) begin
                rd_hold_q <= DATA_W'(load_result);
            end
        end
    end

    // Overlay buffered bytes on the RAM word, then extend.
    always_comb begin
        merged = ram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_mask_q[b]) begin
                merged[8*b +: 8] = fwd_data_q[8*b +: 8];
            end
        end
        load_result = load_extend(merged, f3_q, off_q);
    end

    // Result is built only from flops; it is held between loads.
    assign rd_data        = ld_valid_q ? DATA_W'(load_result) : rd_hold_q;
    assign rd_valid       = ld_valid_q;
    assign err_misaligned = err_q;
    assign sb_count       = sb_count_q;
    assign sb_empty       = empty;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus a randomized mix of
// loads and stores checked against a byte-array memory model.
module tb_dmem_responder;

  localparam int SB_DEPTH = 4;
  localparam int CNT_W    = $clog2(SB_DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic [8:0]       addr = '0;
  logic [31:0]      wr_data = '0;
  logic [2:0]       funct3 = '0;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             stall;
  logic             err_misaligned;
  logic [CNT_W-1:0] sb_count;
  logic             sb_empty;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .SB_DEPTH(SB_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr             (wr),
    .rd             (rd),
    .addr           (addr),
    .wr_data        (wr_data),
    .funct3         (funct3),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .stall          (stall),
    .err_misaligned (err_misaligned),
    .sb_count       (sb_count),
    .sb_empty       (sb_empty)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fails = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_drv = 1'b0;
  logic [7:0]  mem_model [512];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem_model[int'(a)];
    b1 = mem_model[(int'(a) + 1) % 512];
    b2 = mem_model[(int'(a) + 2) % 512];
    b3 = mem_model[(int'(a) + 3) % 512];
    case (f)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic model_store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
    int n;
    n = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
    for (int k = 0; k < n; k++) mem_model[int'(a) + k] = d[8*k +: 8];
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic e);
    @(negedge clk);
    wr = w; rd = r; addr = a; wr_data = d; funct3 = f; exp_err_drv = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b0);
  endtask

  // Returns once the store will be taken at the next rising edge.
  task automatic store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic legal, output int n_stall);
    n_stall = 0;
    drive(1'b1, 1'b0, a, d, f, !legal);
    #1;
    if (legal) begin
      while (stall && n_stall < 8) begin
        n_stall++;
        @(negedge clk);
        #1;
      end
      if (stall) check_eq("store_stall_timeout", 32'(stall), 32'h0);
      model_store(a, d, f);
    end
  endtask

  task automatic load(input logic [8:0] a, input logic [2:0] f, input logic [31:0] exp,
                      input logic legal);
    drive(1'b0, 1'b1, a, 32'h0, f, !legal);
    if (legal) exp_q.push_back(exp);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin : mon
    logic        e_now;
    logic [31:0] exp_v;
    e_now = exp_err_drv;
    #1;
    if (reset) begin
      check_eq("err_misaligned", 32'(err_misaligned), 32'(e_now));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rd_valid_unexpected", 32'(rd_valid), 32'h0);
        end else begin
          exp_v = exp_q.pop_front();
          check_eq("rd_data", rd_data, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          ns;
    logic [2:0]  f;
    logic [1:0]  o;
    logic [8:0]  a;
    logic [31:0] d;

    for (int i = 0; i < 512; i++) mem_model[i] = 8'h00;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
    check_eq("rst_stall", 32'(stall), 32'h0);
    check_eq("rst_err", 32'(err_misaligned), 32'h0);
    check_eq("rst_sb_count", 32'(sb_count), 32'h0);
    check_eq("rst_sb_empty", 32'(sb_empty), 32'h1);
    @(negedge clk);
    reset = 1'b1;

    // initialise the random-phase region
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      store(9'h100 + 9'(4 * w), d, 3'b010, 1'b1, ns);
    end
    idle(6);

    // 1: store then immediate load, served by forwarding
    store(9'h010, 32'hDEADBEEF, 3'b010, 1'b1, ns);
    load(9'h010, 3'b010, 32'hDEADBEEF, 1'b1);
    idle(5);

    // 2: two byte stores to one lane, newest wins; zero and sign extension
    store(9'h011, 32'h000000AA, 3'b000, 1'b1, ns);
    store(9'h011, 32'h000000BB, 3'b000, 1'b1, ns);
    load(9'h011, 3'b100, 32'h000000BB, 1'b1);
    load(9'h011, 3'b000, 32'hFFFFFFBB, 1'b1);
    idle(5);

    // 3: fill the buffer, stall on the fifth store, then drain
    for (int i = 0; i < 5; i++) begin
      store(9'(4 * i), 32'h30000000 + 32'(i), 3'b010, 1'b1, ns);
      check_eq("t3_stall_cycles", 32'(ns), (i == 4) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      check_eq("t3_sb_count", 32'(sb_count), (i < 4) ? 32'(i + 1) : 32'h4);
    end
    idle(4);
    @(posedge clk);
    #1;
    check_eq("t3_sb_empty", 32'(sb_empty), 32'h1);
    check_eq("t3_sb_count_0", 32'(sb_count), 32'h0);
    load(9'h010, 3'b010, 32'h30000004, 1'b1);
    // wr and rd together: the load is served, the store is dropped
    drive(1'b1, 1'b1, 9'h010, 32'h55555555, 3'b010, 1'b1);
    exp_q.push_back(32'h30000004);
    idle(1);
    @(posedge clk);
    #1;
    check_eq("t3_dropped_store", 32'(sb_count), 32'h0);
    idle(2);

    // 4: halfword store over a drained word
    store(9'h020, 32'hAAAAAAAA, 3'b010, 1'b1, ns);
    idle(3);
    store(9'h022, 32'h00001234, 3'b001, 1'b1, ns);
    load(9'h020, 3'b010, 32'h1234AAAA, 1'b1);
    idle(4);

    // 5: illegal requests leave the buffer alone
    store(9'h030, 32'hC0FFEE11, 3'b010, 1'b1, ns);
    load(9'h003, 3'b001, 32'h0, 1'b0);
    store(9'h006, 32'h12345678, 3'b010, 1'b0, ns);
    load(9'h010, 3'b011, 32'h0, 1'b0);
    store(9'h010, 32'h000000FF, 3'b100, 1'b0, ns);
    @(posedge clk);
    #1;
    check_eq("t5_sb_count", 32'(sb_count), 32'h1);
    idle(3);

    // 6: asynchronous reset with entries pending
    store(9'h040, 32'h11111111, 3'b010, 1'b1, ns);
    store(9'h044, 32'h22222222, 3'b010, 1'b1, ns);
    store(9'h048, 32'h33333333, 3'b010, 1'b1, ns);
    load(9'h020, 3'b010, 32'h1234AAAA, 1'b1);
    @(posedge clk);
    #1;
    check_eq("t6_sb_count_pre", 32'(sb_count), 32'h3);
    #1;
    reset = 1'b0;
    #1;
    check_eq("t6_sb_count", 32'(sb_count), 32'h0);
    check_eq("t6_sb_empty", 32'(sb_empty), 32'h1);
    check_eq("t6_rd_valid", 32'(rd_valid), 32'h0);
    check_eq("t6_rd_data", rd_data, 32'h0);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; exp_err_drv = 1'b0;
    reset = 1'b1;
    load(9'h020, 3'b010, 32'h1234AAAA, 1'b1);
    load(9'h030, 3'b010, 32'hC0FFEE11, 1'b1);
    idle(2);

    // random mix over the initialised region
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      a = 9'h100 + 9'(4 * $urandom_range(0, 15));
      if (kind == 0) begin
        idle(1);
      end else begin
        if (kind == 1) begin
          f = 3'($urandom_range(0, 2));
        end else begin
          case ($urandom_range(0, 4))
            0: f = 3'b000;
            1: f = 3'b001;
            2: f = 3'b010;
            3: f = 3'b100;
            default: f = 3'b101;
          endcase
        end
        if (f == 3'b010) o = 2'b00;
        else if (f == 3'b001 || f == 3'b101) o = 2'($urandom_range(0, 1) * 2);
        else o = 2'($urandom_range(0, 3));
        a = a + 9'(o);
        if (kind == 1) begin
          d = $urandom;
          store(a, d, f, 1'b1, ns);
        end else begin
          load(a, f, model_load(a, f), 1'b1);
        end
      end
    end
    idle(2);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
